// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing-error detect.
// Optional `UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (decision one cycle later).
module uart_receiver #(
    parameter logic [15:0] BAUD_DIVISOR = 16'h1458
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam logic [16:0] HALF_PT = {1'b0, BAUD_DIVISOR};
    localparam logic [16:0] FULL_PT = {BAUD_DIVISOR, 1'b1};

    rx_state_t   state, state_next;
    logic        rx_m, rx_s, rx_d;
    logic [16:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        half_hit, full_hit, bit_val, sample_pt;

`ifdef UART_RX_MAJORITY_EN
    // Voting window is P-1..P+1 with the decision at P+1; the counter is
    // re-timed from that decision so every sample point sits one cycle late
    // rather than drifting by one cycle per bit.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (!reset) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign half_hit = (cnt == HALF_PT + 17'd1);
    assign full_hit = (cnt == FULL_PT);
    assign bit_val  = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign half_hit = (cnt == HALF_PT);
    assign full_hit = (cnt == FULL_PT);
    assign bit_val  = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample_pt  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_d && !rx_s) state_next = RX_START;
            end
            RX_START: begin
                sample_pt = half_hit;
                if (half_hit) state_next = bit_val ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                sample_pt = full_hit;
                if (full_hit && bit_idx == 3'd7) state_next = RX_STOP;
            end
            RX_STOP: begin
                sample_pt = full_hit;
                if (full_hit) state_next = bit_val ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: begin
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            // Busy tracks the state we are entering, so WAIT keeps it high.
            rx_busy   <= (state_next != RX_IDLE);

            if (state_next != state || sample_pt || state == RX_IDLE || state == RX_WAIT)
                cnt <= '0;
            else
                cnt <= cnt + 17'd1;

            if (state == RX_START && sample_pt)
                bit_idx <= '0;

            if (state == RX_DATA && sample_pt) begin
                shift   <= {bit_val, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == RX_STOP && sample_pt) begin
                if (bit_val) begin
                    data_out <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver; behavioural frame model kept as queues/counters.
module tb_uart_receiver;
    localparam logic [15:0] BD  = 16'd4;
    localparam int          BIT = 2 * (int'(BD) + 1);

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid, rx_busy, frame_err;

    int         checks = 0, errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt = 0, exp_fe = 0, both_cnt = 0;
    logic       busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;

    uart_receiver #(.BAUD_DIVISOR(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data_out (data_out),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) got_q.push_back(data_out);
            if (frame_err) fe_cnt++;
            if (rx_valid && frame_err) both_cnt++;
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(logic v, int n, bit glitch);
        for (int c = 0; c < n; c++) begin
            rx = (glitch && c == BIT / 2) ? ~v : v;
            @(negedge clk);
        end
        rx = v;
    endtask

    // Leaves rx at stop_val; caller releases a held-low stop bit.
    task automatic send_frame(logic [7:0] b, int stop_len, logic stop_val, int glitch_bit);
        send_bit(1'b0, BIT, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], BIT, glitch_bit == i);
        send_bit(stop_val, stop_len, 1'b0);
    endtask

    task automatic expect_good(logic [7:0] b);
        exp_q.push_back(b);
        last_good = b;
    endtask

    task automatic compare_rx(string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int gb;
        logic [7:0] b;
        logic [7:0] partial;

        // Reset state
        idle(3);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b1;
        idle(5);

        // Single good frame
        send_frame(8'hA5, BIT, 1'b1, -1);
        expect_good(8'hA5);
        idle(3);
        chk("a5_busy", 32'(rx_busy), 32'd0);
        compare_rx("a5");
        chk("a5_data", 32'(data_out), 32'(last_good));
        chk("a5_ferr", 32'(fe_cnt), 32'(exp_fe));

        // Short low glitch is a false start
        busy_seen = 1'b0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
        chk("glitch_busy", 32'(rx_busy), 32'd0);
        compare_rx("glitch");
        chk("glitch_data", 32'(data_out), 32'(last_good));
        chk("glitch_ferr", 32'(fe_cnt), 32'(exp_fe));

        // Stop bit held low: framing error, busy held until release
        send_frame(8'h3C, 20, 1'b0, -1);
        exp_fe++;
        chk("brk_busy_low", 32'(rx_busy), 32'd1);
        chk("brk_ferr", 32'(fe_cnt), 32'(exp_fe));
        idle(5);
        rx = 1'b1;
        idle(6);
        chk("brk_busy_rel", 32'(rx_busy), 32'd0);
        chk("brk_data", 32'(data_out), 32'(last_good));
        compare_rx("brk");
        send_frame(8'h11, BIT, 1'b1, -1);
        expect_good(8'h11);
        idle(3);
        compare_rx("after_brk");
        chk("after_brk_data", 32'(data_out), 32'(last_good));

        // Back-to-back with a single stop bit
        send_frame(8'h00, BIT, 1'b1, -1);
        expect_good(8'h00);
        send_frame(8'hFF, BIT, 1'b1, -1);
        expect_good(8'hFF);
        idle(3);
        compare_rx("b2b");
        chk("b2b_data", 32'(data_out), 32'(last_good));

        // Reset mid-frame during data bit 4 of 0x77
        partial = 8'h77;
        send_bit(1'b0, BIT, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i], BIT, 1'b0);
        send_bit(partial[4], BIT / 2, 1'b0);
        reset = 1'b0;
        idle(2);
        last_good = 8'h00;
        chk("mid_rst_data", 32'(data_out), 32'(last_good));
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b1;
        rx = 1'b1;
        idle(30);
        compare_rx("mid_rst");
        send_frame(8'h5A, BIT, 1'b1, -1);
        expect_good(8'h5A);
        idle(3);
        compare_rx("post_rst");
        chk("post_rst_data", 32'(data_out), 32'(last_good));

        // Loopback-style frame 0x81, glitched at bit 3 when voting is enabled
`ifdef UART_RX_MAJORITY_EN
        gb = 3;
`else
        gb = -1;
`endif
        send_frame(8'h81, BIT, 1'b1, gb);
        expect_good(8'h81);
        idle(3);
        compare_rx("loop81");
        chk("loop81_data", 32'(data_out), 32'(last_good));

        // Randomized frames, occasionally with a broken stop bit
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(b, 15, 1'b0, -1);
                exp_fe++;
                rx = 1'b1;
                idle(5);
            end else begin
                send_frame(b, BIT, 1'b1, -1);
                expect_good(b);
            end
            idle($urandom_range(0, 3));
        end
        idle(5);
        compare_rx("rand");
        chk("rand_data", 32'(data_out), 32'(last_good));
        chk("rand_ferr", 32'(fe_cnt), 32'(exp_fe));
        chk("rand_busy", 32'(rx_busy), 32'd0);
        chk("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
